// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_e;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply (acc = {hi, multiplier}) or
// restoring shift-subtract divide (acc = {remainder, dividend/quotient}).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Partial remainder after the left shift can need XLEN+1 bits.
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    ge     = rem_sh >= {1'b0, opnd_i};
    diff   = rem_sh[XLEN-1:0] - opnd_i;
    if (is_div_i) acc_o = {(ge ? diff : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], ge};
    else          acc_o = {sum, acc_i[XLEN-1:1]};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit (IDLE -> CALC -> FIX -> DONE).
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the multiplier runs out of ones.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN,
  parameter int OPW  = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      regwriteaddress,
  output logic            write
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d, op_in;
  logic [2*XLEN-1:0] acc_q, acc_d, step_acc, prod_fix;
  logic [XLEN-1:0]   opnd_q, opnd_d, res_q, res_d;
  logic [XLEN-1:0]   mag_a, mag_b, fix_sel;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [4:0]        rd_q, rd_d;
  logic              sa, sb, div_zero, div_ovf;
`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0]   mplr_q, mplr_d;
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div(op_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    op_in    = muldiv_op_e'(op);
    sa       = is_signed_a(op_in) & rs1_val[XLEN-1];
    sb       = is_signed_b(op_in) & rs2_val[XLEN-1];
    mag_a    = sa ? -rs1_val : rs1_val;
    mag_b    = sb ? -rs2_val : rs2_val;
    div_zero = is_div(op_in) && (rs2_val == '0);
    div_ovf  = is_div(op_in) && is_signed_b(op_in) && (rs1_val == MIN_NEG) && (rs2_val == '1);
  end

  // Low half of a negated product equals the negated low half, so DIV reuses prod_fix.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    case (op_q)
      OP_MUL:                       fix_sel = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_sel = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_sel = prod_fix[XLEN-1:0];
      default:                      fix_sel = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rd_d    = rd_q;
    res_d   = res_q;
`ifdef MULDIV_EARLY_OUT_EN
    mplr_d  = mplr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_in;
          rd_d    = rd;
          cnt_d   = CW'(XLEN - 1);
          neg_d   = is_rem(op_in) ? sa : (sa ^ sb);
          state_d = S_CALC;
          if (is_div(op_in)) begin
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{XLEN{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
`ifdef MULDIV_EARLY_OUT_EN
          mplr_d = mag_b;
`endif
          // Fast-path results are loaded pre-signed so FIX passes them through.
          if (div_zero) begin
            acc_d   = {rs1_val, DIV_BY_ZERO_Q};
            neg_d   = 1'b0;
            state_d = S_FIX;
          end else if (div_ovf) begin
            acc_d   = {{XLEN{1'b0}}, rs1_val};
            neg_d   = 1'b0;
            state_d = S_FIX;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (!is_div(op_in) && (mag_b == '0)) begin
            acc_d   = '0;
            state_d = S_FIX;
          end
`endif
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
        mplr_d = mplr_q >> 1;
        // Remaining iterations would only shift; do them all at once.
        if (!is_div(op_q) && (mplr_q == '0)) begin
          acc_d   = acc_q >> ({1'b0, cnt_q} + 1'b1);
          state_d = S_FIX;
        end
`endif
      end
      S_FIX: begin
        res_d   = fix_sel;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      mplr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
`ifdef MULDIV_EARLY_OUT_EN
      mplr_q  <= mplr_d;
`endif
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign write           = done && (rd_q != '0);
  assign result          = res_q;
  assign regwriteaddress = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit with an arithmetic reference model and per-cycle compare.
module tb_muldiv_unit;

  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [63:0] rs1_val, rs2_val, result;
  logic [4:0]  rd, regwriteaddress;
  logic        busy, done, write;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit          exp_valid, exp_flex;
  logic [63:0] exp_res, last_res;
  logic [4:0]  exp_rd, last_rd;
  int          exp_samp, exp_due;

  muldiv_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd),
    .busy(busy), .done(done), .result(result),
    .regwriteaddress(regwriteaddress), .write(write)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    longint sa, sb;
    ea = {64'b0, a};
    eb = {64'b0, b};
    if (o == 3'd1 || o == 3'd2) ea = {{64{a[63]}}, a};
    if (o == 3'd1) eb = {{64{b[63]}}, b};
    p  = ea * eb;
    sa = a;
    sb = b;
    case (o)
      3'd0: return p[63:0];
      3'd1, 3'd2, 3'd3: return p[127:64];
      3'd4: begin
        if (b == 64'd0) return '1;
        if (a == MIN && b == '1) return a;
        return sa / sb;
      end
      3'd5: return (b == 64'd0) ? '1 : a / b;
      3'd6: begin
        if (b == 64'd0) return a;
        if (a == MIN && b == '1) return 64'd0;
        return sa % sb;
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return MIN;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] r);
    bit fast;
    @(posedge clock); #1;
    fast     = (o[2] && b == 64'd0) || ((o == 3'd4 || o == 3'd6) && a == MIN && b == '1);
    start    = 1'b1;
    op       = o;
    rs1_val  = a;
    rs2_val  = b;
    rd       = r;
    exp_res  = model(o, a, b);
    exp_rd   = r;
    exp_samp = cyc + 1;
    exp_due  = cyc + (fast ? 2 : 66);
    exp_flex = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    exp_flex = !o[2];
`endif
    exp_valid = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Scrambles inputs and pulses start while busy; optional mid-op reset at step rst_at.
  task automatic wait_done(input int rst_at);
    int n;
    n = 0;
    while (exp_valid && n < 100) begin
      if (n == rst_at) begin
        reset = 1'b1;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_write", 64'(write), 64'd0);
        chk("reset_result", result, 64'd0);
        exp_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        return;
      end
      rs1_val = {$urandom, $urandom};
      rs2_val = {$urandom, $urandom};
      op      = 3'($urandom_range(0, 7));
      rd      = 5'($urandom_range(0, 31));
      start   = (n == 9) || ($urandom_range(0, 3) == 0);
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    if (exp_valid) begin
      chk("timeout_done", 64'd0, 64'd1);
      exp_valid = 1'b0;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] r);
    launch(o, a, b, r);
    wait_done(-1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; rs1_val = '0; rs2_val = '0; rd = '0;
    exp_valid = 1'b0; exp_flex = 1'b0; exp_res = '0; exp_rd = '0;
    last_res = '0; last_rd = '0; exp_samp = 0; exp_due = 0;

    chk("pin_mul", model(3'd0, 64'd7, 64'd6), 64'd42);
    chk("pin_mulh", model(3'd1, '1, '1), 64'd0);
    chk("pin_mulhu", model(3'd3, '1, '1), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_mulhsu", model(3'd2, '1, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_div", model(3'd4, -64'd7, 64'd2), -64'd3);
    chk("pin_rem", model(3'd6, -64'd7, 64'd2), -64'd1);
    chk("pin_divu", model(3'd5, 64'd100, 64'd7), 64'd14);
    chk("pin_remu", model(3'd7, 64'd100, 64'd7), 64'd2);
    chk("pin_divz", model(3'd5, 64'd9, 64'd0), '1);
    chk("pin_remz", model(3'd7, 64'd9, 64'd0), 64'd9);
    chk("pin_ovf", model(3'd4, MIN, '1), MIN);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_rwaddr", 64'(regwriteaddress), 64'd0);
    reset = 1'b0;

    fork
      begin
        run_op(3'd0, 64'd7, 64'd6, 5'd5);
        run_op(3'd1, '1, '1, 5'd1);
        run_op(3'd3, '1, '1, 5'd2);
        run_op(3'd2, '1, 64'd2, 5'd3);
        run_op(3'd4, -64'd7, 64'd2, 5'd4);
        run_op(3'd6, -64'd7, 64'd2, 5'd6);
        run_op(3'd5, 64'd100, 64'd7, 5'd7);
        run_op(3'd7, 64'd100, 64'd7, 5'd8);
        run_op(3'd5, 64'd9, 64'd0, 5'd9);
        run_op(3'd7, 64'd9, 64'd0, 5'd10);
        run_op(3'd4, MIN, '1, 5'd11);
        run_op(3'd6, MIN, '1, 5'd12);
        run_op(3'd4, -64'd5, 64'd0, 5'd13);
        launch(3'd0, 64'd123, 64'd456, 5'd14);
        wait_done(29);
        run_op(3'd0, 64'd3, 64'd3, 5'd15);
        run_op(3'd0, 64'd5, 64'd5, 5'd0);
        for (int i = 0; i < 40; i++)
          run_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)));
        repeat (3) @(posedge clock);
      end
      begin : compare
        bit act;
        forever begin
          @(negedge clock);
          if (reset) begin
            last_res = '0;
            last_rd  = '0;
          end else begin
            act = exp_valid && (cyc >= exp_samp);
            if (act && (cyc == exp_due || (exp_flex && done))) begin
              chk("done_pulse", 64'(done), 64'd1);
              chk("busy_at_done", 64'(busy), 64'd1);
              chk("result", result, exp_res);
              chk("write", 64'(write), 64'(exp_rd != 5'd0));
              chk("rwaddr", 64'(regwriteaddress), 64'(exp_rd));
              last_res  = exp_res;
              last_rd   = exp_rd;
              exp_valid = 1'b0;
            end else begin
              chk("busy", 64'(busy), 64'(act));
              chk("no_done", 64'(done), 64'd0);
              chk("no_write", 64'(write), 64'd0);
              chk("result_held", result, last_res);
              chk("rwaddr_held", 64'(regwriteaddress), 64'(act ? exp_rd : last_rd));
            end
          end
        end
      end
    join_any
    disable fork;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
